// File: rtl/systolic_input_skewer.sv
// Diagonal-skew feeder for an NxN systolic array: lane i is delayed i+1 cycles, then drains with zeros.
// Define SKEW_PERF_CNT_EN to enable the stall_cycles counter; otherwise stall_cycles is tied to zero.
module systolic_skew_lane #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1
) (
  input  logic              clk,
  input  logic              rst_flush,
  input  logic              i_adv,
  input  logic [DATA_W-1:0] i_din,
  output logic [DATA_W-1:0] o_dout
);
  logic [DEPTH-1:0][DATA_W-1:0] r_sr;

  always_ff @(posedge clk) begin
    if (rst_flush) begin
      r_sr <= '0;
    end else if (i_adv) begin
      r_sr[0] <= i_din;
      for (int k = 1; k < DEPTH; k++) r_sr[k] <= r_sr[k-1];
    end
  end

  assign o_dout = r_sr[DEPTH-1];
endmodule

module systolic_input_skewer #(
  parameter int DATA_W      = 32,
  parameter int N           = 8,
  parameter int K_W         = 9,
  parameter int DRAIN_EXTRA = 1
) (
  input  logic                clk,
  input  logic                rst_flush,
  input  logic                start,
  input  logic [K_W-1:0]      k_len,
  input  logic [N*DATA_W-1:0] a_vec,
  input  logic [N*DATA_W-1:0] b_vec,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [N*DATA_W-1:0] inp_west,
  output logic [N*DATA_W-1:0] inp_north,
  output logic                valid,
  output logic                complete_matmul,
  input  logic                result_w_comp,
  output logic                busy,
  output logic [15:0]         stall_cycles
);
  localparam int DRAIN_LEN = 2*N - 1 + DRAIN_EXTRA;
  localparam int DC_W      = $clog2(DRAIN_LEN + 1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  state_t          r_state;
  logic [K_W-1:0]  r_k;
  logic [K_W-1:0]  r_beat;
  logic [DC_W-1:0] r_drain;
  logic            r_valid;
  logic            r_cmp;
  logic            w_stream;
  logic            w_drain;
  logic            w_adv;

  assign w_stream = (r_state == STREAM);
  assign w_drain  = (r_state == DRAIN);
  // Chains move on accepted beats and on every drain cycle; everything else freezes them.
  assign w_adv    = (w_stream & in_valid) | w_drain;

  always_ff @(posedge clk) begin
    if (rst_flush) begin
      r_state <= IDLE;
      r_k     <= '0;
      r_beat  <= '0;
      r_drain <= '0;
      r_valid <= 1'b0;
      r_cmp   <= 1'b0;
    end else begin
      r_valid <= w_adv;
      r_cmp   <= (r_state == DONE) && !result_w_comp;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (k_len != '0) begin
              r_k     <= k_len;
              r_beat  <= '0;
              r_state <= STREAM;
            end else begin
              r_state <= DONE;
            end
          end
        end
        STREAM: begin
          if (in_valid) begin
            r_beat <= r_beat + 1'b1;
            if (r_beat == r_k - 1'b1) begin
              r_drain <= '0;
              r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          r_drain <= r_drain + 1'b1;
          if (r_drain == DC_W'(DRAIN_LEN - 1)) r_state <= DONE;
        end
        DONE: begin
          if (result_w_comp) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready        = w_stream;
  assign valid           = r_valid;
  assign complete_matmul = r_cmp;
  assign busy            = (r_state != IDLE);

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DATA_W-1:0] w_a_in;
    logic [DATA_W-1:0] w_b_in;
    assign w_a_in = w_stream ? a_vec[i*DATA_W +: DATA_W] : '0;
    assign w_b_in = w_stream ? b_vec[i*DATA_W +: DATA_W] : '0;

    systolic_skew_lane #(.DATA_W(DATA_W), .DEPTH(i+1)) u_west (
      .clk      (clk),
      .rst_flush(rst_flush),
      .i_adv    (w_adv),
      .i_din    (w_a_in),
      .o_dout   (inp_west[i*DATA_W +: DATA_W])
    );

    systolic_skew_lane #(.DATA_W(DATA_W), .DEPTH(i+1)) u_north (
      .clk      (clk),
      .rst_flush(rst_flush),
      .i_adv    (w_adv),
      .i_din    (w_b_in),
      .o_dout   (inp_north[i*DATA_W +: DATA_W])
    );
  end

`ifdef SKEW_PERF_CNT_EN
  logic [15:0] r_stall;

  always_ff @(posedge clk) begin
    if (rst_flush) begin
      r_stall <= '0;
    end else if ((r_state == IDLE) && start && (k_len != '0)) begin
      r_stall <= '0;
    end else if (w_stream && !in_valid && (r_stall != 16'hFFFF)) begin
      r_stall <= r_stall + 16'd1;
    end
  end

  assign stall_cycles = r_stall;
`else
  assign stall_cycles = 16'h0;
`endif
endmodule

// File: tb/tb_systolic_input_skewer.sv
// Directed bench for systolic_input_skewer: a per-advance history queue predicts every skewed lane.
module tb_systolic_input_skewer;
  localparam int DATA_W = 32;
  localparam int N      = 8;
  localparam int K_W    = 9;
  localparam int VW     = N*DATA_W;
  localparam int DRAIN  = 16;

  logic           clk = 1'b0;
  logic           rst_flush, start, in_valid, result_w_comp;
  logic [K_W-1:0] k_len;
  logic [VW-1:0]  a_vec, b_vec, inp_west, inp_north;
  logic           in_ready, valid, complete_matmul, busy;
  logic [15:0]    stall_cycles;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [VW-1:0] a;
    logic [VW-1:0] b;
  } beat_t;

  // Lane inputs in order of advance; newest at the back.
  beat_t hist[$];

  systolic_input_skewer dut (
    .clk            (clk),
    .rst_flush      (rst_flush),
    .start          (start),
    .k_len          (k_len),
    .a_vec          (a_vec),
    .b_vec          (b_vec),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .inp_west       (inp_west),
    .inp_north      (inp_north),
    .valid          (valid),
    .complete_matmul(complete_matmul),
    .result_w_comp  (result_w_comp),
    .busy           (busy),
    .stall_cycles   (stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] rnd();
    logic [VW-1:0] v;
    for (int i = 0; i < N; i++) v[i*DATA_W +: DATA_W] = $urandom;
    return v;
  endfunction

  function automatic logic [VW-1:0] ramp(input int base);
    logic [VW-1:0] v;
    for (int i = 0; i < N; i++) v[i*DATA_W +: DATA_W] = DATA_W'(base + i);
    return v;
  endfunction

  function automatic logic [VW-1:0] unit(input int k);
    logic [VW-1:0] v;
    v = '0;
    v[k*DATA_W +: DATA_W] = DATA_W'(1);
    return v;
  endfunction

  // Lane i shows the value that entered i advances before the newest one.
  function automatic logic [VW-1:0] exp_vec(input logic sel_b);
    logic [VW-1:0] v;
    beat_t e;
    v = '0;
    for (int i = 0; i < N; i++) begin
      if (hist.size() > i) begin
        e = hist[hist.size()-1-i];
        v[i*DATA_W +: DATA_W] = sel_b ? e.b[i*DATA_W +: DATA_W] : e.a[i*DATA_W +: DATA_W];
      end
    end
    return v;
  endfunction

  task automatic push(input logic [VW-1:0] a, input logic [VW-1:0] b);
    hist.push_back('{a: a, b: b});
    if (hist.size() > N) void'(hist.pop_front());
  endtask

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic ev, input logic er);
    chk({tag, "_west"},  inp_west,  exp_vec(1'b0));
    chk({tag, "_north"}, inp_north, exp_vec(1'b1));
    chk({tag, "_valid"}, VW'(valid),    VW'(ev));
    chk({tag, "_ready"}, VW'(in_ready), VW'(er));
  endtask

  task automatic step(input string tag, input logic iv, input logic [VW-1:0] a,
                      input logic [VW-1:0] b, input logic adv, input logic er);
    in_valid = iv; a_vec = a; b_vec = b;
    @(posedge clk); #1;
    if (adv) push(a, b);
    check_out(tag, adv, er);
  endtask

  task automatic begin_mm(input string tag, input int k);
    start = 1'b1; k_len = K_W'(k);
    in_valid = 1'b1; a_vec = rnd(); b_vec = rnd();
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0;
    check_out(tag, 1'b0, 1'b1);
    chk({tag, "_busy"}, VW'(busy), VW'(1'b1));
  endtask

  task automatic drain(input string tag);
    for (int d = 0; d < DRAIN; d++) begin
      in_valid = 1'b1; a_vec = rnd(); b_vec = rnd();
      @(posedge clk); #1;
      push('0, '0);
      check_out(tag, 1'b1, 1'b0);
    end
    in_valid = 1'b0;
    chk({tag, "_cmp_lo"},  VW'(complete_matmul), VW'(1'b0));
    chk({tag, "_busy_hi"}, VW'(busy),            VW'(1'b1));
  endtask

  task automatic finish_mm(input string tag, input int hold);
    @(posedge clk); #1;
    check_out({tag, "_done"}, 1'b0, 1'b0);
    chk({tag, "_cmp_rise"}, VW'(complete_matmul), VW'(1'b1));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({tag, "_cmp_hold"}, VW'(complete_matmul), VW'(1'b1));
    end
    result_w_comp = 1'b1;
    @(posedge clk); #1;
    result_w_comp = 1'b0;
    chk({tag, "_cmp_fall"}, VW'(complete_matmul), VW'(1'b0));
    chk({tag, "_idle"},     VW'(busy),            VW'(1'b0));
  endtask

  initial begin
    logic [VW-1:0] bm[N];
    logic [15:0]   exp_stall;
`ifdef SKEW_PERF_CNT_EN
    exp_stall = 16'd6;
`else
    exp_stall = 16'd0;
`endif
    rst_flush = 1'b1; start = 1'b0; in_valid = 1'b0; result_w_comp = 1'b0;
    k_len = '0; a_vec = '0; b_vec = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_flush = 1'b0;
    check_out("rst", 1'b0, 1'b0);
    chk("rst_cmp",   VW'(complete_matmul), '0);
    chk("rst_busy",  VW'(busy),            '0);
    chk("rst_stall", VW'(stall_cycles),    '0);

    // T2: single beat, ramped lanes expose each lane's latency.
    begin_mm("t2_start", 1);
    step("t2_beat", 1'b1, ramp(1), ramp(11), 1'b1, 1'b0);
    drain("t2_drain");
    finish_mm("t2", 3);

    // T3: K=8, A=identity, B random, no stalls; a start mid-stream must be ignored.
    for (int k = 0; k < N; k++) bm[k] = rnd();
    begin_mm("t3_start", 8);
    for (int k = 0; k < N; k++) begin
      if (k == 3) begin start = 1'b1; k_len = K_W'(3); end
      step("t3_beat", 1'b1, unit(k), bm[k], 1'b1, k != N-1);
      start = 1'b0;
    end
    drain("t3_drain");
    chk("t3_stall", VW'(stall_cycles), '0);
    finish_mm("t3", 1);

    // T4: same operands with two 3-cycle stalls, before beats 2 and 5.
    begin_mm("t4_start", 8);
    for (int k = 0; k < N; k++) begin
      if (k == 1 || k == 4)
        for (int s = 0; s < 3; s++) step("t4_stall", 1'b0, rnd(), rnd(), 1'b0, 1'b1);
      step("t4_beat", 1'b1, unit(k), bm[k], 1'b1, k != N-1);
    end
    chk("t4_stall_cnt", VW'(stall_cycles), VW'(exp_stall));
    drain("t4_drain");
    finish_mm("t4", 0);
    chk("t4_stall_hold", VW'(stall_cycles), VW'(exp_stall));

    // T1: reset on the fourth beat of a K=8 matmul aborts with no drain.
    begin_mm("t1_start", 8);
    for (int k = 0; k < 3; k++) step("t1_beat", 1'b1, rnd(), rnd(), 1'b1, 1'b1);
    rst_flush = 1'b1; in_valid = 1'b1; a_vec = rnd(); b_vec = rnd();
    @(posedge clk); #1;
    rst_flush = 1'b0;
    hist.delete();
    check_out("t1_rst", 1'b0, 1'b0);
    chk("t1_rst_busy",  VW'(busy),            '0);
    chk("t1_rst_cmp",   VW'(complete_matmul), '0);
    chk("t1_rst_stall", VW'(stall_cycles),    '0);
    for (int k = 0; k < 5; k++) step("t1_ignored", 1'b1, rnd(), rnd(), 1'b0, 1'b0);
    chk("t1_still_idle", VW'(busy), '0);

    // T5: k_len=0 goes straight to DONE; result_w_comp beats a simultaneous start.
    start = 1'b1; k_len = '0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("t5_busy",     VW'(busy),            VW'(1'b1));
    chk("t5_cmp_lo",   VW'(complete_matmul), '0);
    chk("t5_valid0",   VW'(valid),           '0);
    @(posedge clk); #1;
    chk("t5_cmp_hi",   VW'(complete_matmul), VW'(1'b1));
    chk("t5_valid1",   VW'(valid),           '0);
    result_w_comp = 1'b1; start = 1'b1; k_len = K_W'(4);
    @(posedge clk); #1;
    result_w_comp = 1'b0; start = 1'b0;
    chk("t5_cmp_fall", VW'(complete_matmul), '0);
    chk("t5_idle",     VW'(busy),            '0);
    @(posedge clk); #1;
    chk("t5_no_start", VW'(busy),            '0);
    chk("t5_no_ready", VW'(in_ready),        '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
